// File: rtl/codificador_mux_display.sv
// Time-multiplexed BCD/hex to 7-segment driver for N_DIGITS digits on a shared
// segment bus. A prescaler advances a one-hot digit scan. Loaded words wait in
// a pending buffer and move to the display buffer only at frame boundaries, so
// a frame never shows a mix of old and new digits.
module codificador_mux_display #(
    parameter int N_DIGITS   = 4,
    parameter int DIV        = 1000,
    parameter int HEX_MODE   = 0,
    parameter int SEG_ACT_LO = 0,
    parameter int AN_ACT_LO  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank_lz,
    output logic [7:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_tick,
    output logic                  pending
);
    localparam int CUR_W  = $clog2(N_DIGITS);
    localparam int CNT_W  = $clog2(DIV);
    localparam int WORD_W = 5 * N_DIGITS;
    localparam logic [CUR_W-1:0] LAST_DIGIT = CUR_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DIV - 1);

    // Buffer layout: {dp[N-1:0], digit codes[4N-1:0]}
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CUR_W-1:0]    cur_q, cur_d;
    logic [WORD_W-1:0]   pend_q, pend_d;
    logic [WORD_W-1:0]   disp_q, disp_d;
    logic                pending_q, pending_d;
    logic                frame_tick_q, frame_tick_d;
    logic [7:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] an_q, an_d;

    logic                tick;
    logic                boundary;
    logic [N_DIGITS-1:0] blank_mask;
    logic                zero_run;
    logic [3:0]          cur_code;
    logic                cur_dp;

    // Active-high glyph lookup, segment a in bit 0.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        if (code > 4'd9 && HEX_MODE == 0) begin
            g = 7'h40;
        end
        return g;
    endfunction

    // Next-state logic: prescaler, scan pointer, double buffer and registered outputs.
    always_comb begin
        tick         = (cnt_q == LAST_COUNT);
        boundary     = tick && (cur_q == LAST_DIGIT);
        cnt_d        = tick ? '0 : cnt_q + 1'b1;
        cur_d        = cur_q;
        pend_d       = pend_q;
        disp_d       = disp_q;
        pending_d    = pending_q;
        frame_tick_d = boundary;
        seg_d        = seg_q;
        an_d         = an_q;
        blank_mask   = '0;
        zero_run     = blank_lz;

        if (tick) begin
            cur_d = (cur_q == LAST_DIGIT) ? '0 : cur_q + 1'b1;
        end

        // A load coinciding with the boundary bypasses the pending buffer.
        if (boundary) begin
            if (load) begin
                disp_d = {dp_in, bcd_in};
            end else if (pending_q) begin
                disp_d = pend_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pend_d    = {dp_in, bcd_in};
            pending_d = 1'b1;
        end

        // Leading zeros counted from the most significant digit down; digit 0 always shown.
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_run      = zero_run && (disp_d[4*k +: 4] == 4'h0);
            blank_mask[k] = zero_run;
        end

        // Outputs are built from the buffer contents that will be live after this edge.
        cur_code = disp_d[4*int'(cur_d) +: 4];
        cur_dp   = disp_d[4*N_DIGITS + int'(cur_d)];
        if (tick) begin
            an_d        = '0;
            an_d[cur_d] = 1'b1;
            seg_d       = {cur_dp, blank_mask[cur_d] ? 7'h00 : glyph(cur_code)};
        end
    end

    // State registers; reset parks the scan on the last digit so the first tick lights digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            cur_q        <= LAST_DIGIT;
            pend_q       <= '0;
            disp_q       <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            seg_q        <= '0;
            an_q         <= '0;
        end else begin
            cnt_q        <= cnt_d;
            cur_q        <= cur_d;
            pend_q       <= pend_d;
            disp_q       <= disp_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign seg        = (SEG_ACT_LO != 0) ? ~seg_q : seg_q;
    assign an         = (AN_ACT_LO != 0) ? ~an_q : an_q;
    assign frame_tick = frame_tick_q;
    assign pending    = pending_q;

endmodule
